// File: rtl/reg_wb_pkg.sv
// ---------------------------------------------------------------------------
// reg_wb_pkg
//   Shared constants and types for the register-file write-back arbiter.
//
//   ZERO_REG_ADDR  address of the hardwired zero register; writes to it are
//                  accepted by the handshake but never reach the register file
//   MAX_NUM_REQ    largest supported number of write-back producers
//   WB_ADDR_WIDTH  default register address width
//   WB_DATA_WIDTH  default register data width
//   wb_req_t       one write-back request {addr, data} at the default widths
// ---------------------------------------------------------------------------
package reg_wb_pkg;

    localparam int ZERO_REG_ADDR = 0;
    localparam int MAX_NUM_REQ   = 8;
    localparam int MIN_NUM_REQ   = 2;

    localparam int WB_ADDR_WIDTH = 8;
    localparam int WB_DATA_WIDTH = 8;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage : reg_wb_pkg

// File: rtl/reg_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Scans the request vector starting at
//   ptr and wrapping modulo NUM_REQ; the first set request wins.
//
//   Ports
//     req        in   NUM_REQ  request vector
//     ptr        in   PTR_W    index of the highest-priority requester
//     en         in   1        when low no grant is issued at all
//     grant      out  NUM_REQ  one-hot grant (all zero when nothing granted)
//     grant_idx  out  PTR_W    index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // Position k of the scan, rotated so that ptr is looked at first.
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = PTR_W'(idx);
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//   Write-back arbiter and staging register for the single register-file
//   write port. One producer is granted per cycle, round-robin; the granted
//   write is staged for one cycle and driven onto the write port, and the
//   staged write is exposed to readers through forwarding compares.
//
//   Handshake: a producer raises req_valid[i] with req_addr[i]/req_data[i]
//   and holds all three stable until it sees req_ready[i]. A transfer happens
//   in the cycle where req_valid[i] & req_ready[i]. req_ready is one-hot,
//   combinational, and never set for a requester whose valid is low.
//
//   Ports
//     clk, rst              clock; asynchronous active-high reset
//     pause                 blocks every grant while high (pointer holds)
//     req_valid/addr/data   per-requester write request
//     req_ready             one-hot grant
//     wb_en/addr/data       register-file write port (staged, 1 cycle after grant)
//     rd_addr_1/2           snooped register-file read addresses
//     fwd_hit_1/2           staged write targets the matching read address
//     fwd_data              staged write data (same as wb_data)
// ---------------------------------------------------------------------------
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pause,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 wb_en,
    output logic [ADDR_WIDTH-1:0]                wb_addr,
    output logic [DATA_WIDTH-1:0]                wb_data,
    input  logic [ADDR_WIDTH-1:0]                rd_addr_1,
    input  logic [ADDR_WIDTH-1:0]                rd_addr_2,
    output logic                                 fwd_hit_1,
    output logic                                 fwd_hit_2,
    output logic [DATA_WIDTH-1:0]                fwd_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
            $error("reg_wb_arbiter: NUM_REQ out of supported range");
        end
    endgenerate

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_nonzero;

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (~pause),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready   = grant;
    assign grant_any   = |grant;
    assign sel_addr    = req_addr[grant_idx];
    assign sel_data    = req_data[grant_idx];
    assign sel_nonzero = (sel_addr != ADDR_WIDTH'(ZERO_REG_ADDR));

    // The requester after the winner becomes highest priority; with no grant
    // (idle or paused) the pointer stays put.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_any) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Staging register
    //   wb_en is refreshed every cycle, so a write lasts exactly one cycle.
    //   Zero-register writes complete the handshake but leave wb_en low;
    //   address/data still capture them so wb_addr/wb_data always reflect the
    //   most recent grant.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= grant_any & sel_nonzero;
            if (grant_any) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding: readers see the staged write before the register file does.
    // Gating by wb_en keeps address 0 from ever hitting.
    // -----------------------------------------------------------------------
    assign fwd_hit_1 = wb_en & (wb_addr == rd_addr_1);
    assign fwd_hit_2 = wb_en & (wb_addr == rd_addr_2);
    assign fwd_data  = wb_data;

endmodule : reg_wb_arbiter

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
    import reg_wb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int N  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pause;
    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic [AW-1:0]        rd_addr_1;
    logic [AW-1:0]        rd_addr_2;
    logic                 fwd_hit_1;
    logic                 fwd_hit_2;
    logic [DW-1:0]        fwd_data;

    reg_wb_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_1 (rd_addr_1),
        .rd_addr_2 (rd_addr_2),
        .fwd_hit_1 (fwd_hit_1),
        .fwd_hit_2 (fwd_hit_2),
        .fwd_data  (fwd_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] exp_q[$];

    // reference model state
    int      m_ptr;
    logic    m_en;
    wb_req_t m_stage;
    logic [N-1:0] accepted_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic p, input logic [N-1:0] v,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        pause       = p;
        req_valid   = v;
        req_addr[0] = a0;
        req_data[0] = d0;
        req_addr[1] = a1;
        req_data[1] = d1;
        rd_addr_1   = r1;
        rd_addr_2   = r2;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Winner = valid requester closest at or after the pointer, modulo N.
    function automatic int exp_winner(input logic [N-1:0] v, input logic p, input int ptr);
        int best;
        int best_d;
        best   = -1;
        best_d = N;
        if (!p) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && (((i - ptr) + N) % N) < best_d) begin
                    best_d = ((i - ptr) + N) % N;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          p;
        logic [N-1:0]  v;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [N-1:0]  exp_ready;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_hit1;
        logic          exp_hit2;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // single request
        vecs[0]  = '{1'b0, 2'b01, 8'h05, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 2'b01, 1'b1, 8'h05, 8'hA5, 1'b1, 1'b0};
        // contention, pointer now 1
        vecs[1]  = '{1'b0, 2'b11, 8'h01, 8'h11, 8'h02, 8'h22, 8'h02, 8'h01, 2'b10, 1'b1, 8'h02, 8'h22, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 8'h01, 8'h11, 8'h02, 8'h22, 8'h02, 8'h01, 2'b01, 1'b1, 8'h01, 8'h11, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'b11, 8'h01, 8'h11, 8'h02, 8'h22, 8'h02, 8'h01, 2'b10, 1'b1, 8'h02, 8'h22, 1'b1, 1'b0};
        // zero register write from req1: accepted, dropped, pointer wraps to 0
        vecs[4]  = '{1'b0, 2'b10, 8'h01, 8'h11, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b10, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0};
        // forwarding
        vecs[5]  = '{1'b0, 2'b01, 8'h03, 8'h3C, 8'h00, 8'h00, 8'h03, 8'h04, 2'b01, 1'b1, 8'h03, 8'h3C, 1'b1, 1'b0};
        // pause for three cycles, pointer is 1
        vecs[6]  = '{1'b1, 2'b11, 8'h07, 8'h77, 8'h08, 8'h88, 8'h03, 8'h03, 2'b00, 1'b0, 8'h03, 8'h3C, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b11, 8'h07, 8'h77, 8'h08, 8'h88, 8'h03, 8'h03, 2'b00, 1'b0, 8'h03, 8'h3C, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b11, 8'h07, 8'h77, 8'h08, 8'h88, 8'h03, 8'h03, 2'b00, 1'b0, 8'h03, 8'h3C, 1'b0, 1'b0};
        // release: resumes from held pointer 1
        vecs[9]  = '{1'b0, 2'b11, 8'h07, 8'h77, 8'h08, 8'h88, 8'h08, 8'h07, 2'b10, 1'b1, 8'h08, 8'h88, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 8'h07, 8'h77, 8'h08, 8'h88, 8'h08, 8'h07, 2'b01, 1'b1, 8'h07, 8'h77, 1'b0, 1'b1};
        // idle: staging holds, wb_en drops
        vecs[11] = '{1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07, 2'b00, 1'b0, 8'h07, 8'h77, 1'b0, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        logic [N-1:0] exp_rdy;

        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_en",   wb_en,     1'b0);
        chk("reset_wb_addr", wb_addr,   '0);
        chk("reset_wb_data", wb_data,   '0);
        chk("reset_ready",   req_ready, '0);
        chk("reset_hit1",    fwd_hit_1, 1'b0);
        chk("reset_hit2",    fwd_hit_2, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven directed vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].p, vecs[i].v, vecs[i].a0, vecs[i].d0,
                  vecs[i].a1, vecs[i].d1, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wb_en", i),   wb_en,     vecs[i].exp_en);
            chk($sformatf("vec%0d_wb_addr", i), wb_addr,   vecs[i].exp_addr);
            chk($sformatf("vec%0d_wb_data", i), wb_data,   vecs[i].exp_data);
            chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_hit1", i),    fwd_hit_1, vecs[i].exp_hit1);
            chk($sformatf("vec%0d_hit2", i),    fwd_hit_2, vecs[i].exp_hit2);
        end

        // pause rising while a write is staged: that write still completes
        @(negedge clk);
        drive(1'b0, 2'b01, 8'h0A, 8'h5A, 8'h00, 8'h00, 8'h0A, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b1, 2'b11, 8'h0B, 8'h6B, 8'h0C, 8'h7C, 8'h0A, 8'h00);
        #1;
        chk("pause_staged_en",  wb_en,     1'b1);
        chk("pause_staged_hit", fwd_hit_1, 1'b1);
        chk("pause_ready",      req_ready, 2'b00);
        @(posedge clk);
        #1;
        chk("pause_next_en", wb_en, 1'b0);

        // async reset between edges while a write is staged (pointer is now 1)
        @(negedge clk);
        drive(1'b0, 2'b01, 8'h09, 8'h99, 8'h00, 8'h00, 8'h09, 8'h09);
        @(posedge clk);
        #1;
        chk("pre_rst_en", wb_en, 1'b1);
        #2;
        drive_idle();
        rd_addr_1 = 8'h09;
        rst = 1'b1;
        #1;
        chk("async_rst_en",   wb_en,     1'b0);
        chk("async_rst_addr", wb_addr,   '0);
        chk("async_rst_data", wb_data,   '0);
        chk("async_rst_hit1", fwd_hit_1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2'b11, 8'h0D, 8'hD0, 8'h0E, 8'hE0, 8'h00, 8'h00);
        #1;
        chk("post_rst_first_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        chk("post_rst_wb_addr", wb_addr, 8'h0D);

        // fresh reset before the randomized phase so the model starts aligned
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr         = 0;
        m_en          = 1'b0;
        m_stage       = '0;
        accepted_last = '0;
        exp_q.delete();

        // randomized stimulus against the reference model
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                // a requester that was not yet accepted keeps its request
                if (!(req_valid[i] && !accepted_last[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_addr[i]  = AW'($urandom_range(0, 7));
                    req_data[i]  = DW'($urandom);
                end
            end
            pause     = ($urandom_range(0, 7) == 0);
            rd_addr_1 = AW'($urandom_range(0, 7));
            rd_addr_2 = AW'($urandom_range(0, 7));
            #1;
            w       = exp_winner(req_valid, pause, m_ptr);
            exp_rdy = (w < 0) ? '0 : N'(1 << w);
            chk("rand_ready", req_ready, exp_rdy);

            @(posedge clk);
            accepted_last = exp_rdy;
            if (w >= 0) begin
                m_ptr        = (w + 1) % N;
                m_stage.addr = req_addr[w];
                m_stage.data = req_data[w];
                m_en         = (req_addr[w] != AW'(ZERO_REG_ADDR));
                if (m_en) exp_q.push_back({req_addr[w], req_data[w]});
            end else begin
                m_en = 1'b0;
            end
            #1;
            chk("rand_wb_en",   wb_en,   m_en);
            chk("rand_wb_addr", wb_addr, m_stage.addr);
            chk("rand_wb_data", wb_data, m_stage.data);
            chk("rand_hit1",    fwd_hit_1, m_en && (m_stage.addr == rd_addr_1));
            chk("rand_hit2",    fwd_hit_2, m_en && (m_stage.addr == rd_addr_2));
            if (wb_en) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("rand_write_order", {wb_addr, wb_data}, exp_q.pop_front());
                end
            end
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_wb_arbiter

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and staging register for the shared register-file write port. It accepts write requests from NUM_REQ producers (ALU write-back, load write-back, etc.) with a valid/ready handshake and grants one per cycle, round-robin. The granted write is registered and driven onto the register file's single write port. Same-cycle forwarding outputs let readers see the staged write before it lands.

## Interface
- DATA_WIDTH, 8, width of register data
- ADDR_WIDTH, 8, width of register address
- NUM_REQ, 2, number of requesters (2..8)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pause  in  1  suppresses all grants while high
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester destination address
- req_data  in  NUM_REQ x DATA_WIDTH  per-requester write data
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready
- wb_en  out  1  register-file write enable
- wb_addr  out  ADDR_WIDTH  register-file write address
- wb_data  out  DATA_WIDTH  register-file write data
- rd_addr_1, rd_addr_2  in  ADDR_WIDTH  register-file read addresses (snooped)
- fwd_hit_1, fwd_hit_2  out  1  staged write matches the read address
- fwd_data  out  DATA_WIDTH  staged write data (equal to wb_data)

## Operation
- Round-robin pointer rr_ptr holds the highest-priority requester. Scan starts at rr_ptr and wraps modulo NUM_REQ.
- The first valid requester found in the scan gets req_ready = 1. All other ready bits are 0.
- req_ready is combinational from req_valid, rr_ptr and pause. It never asserts for a requester whose valid is low.
- pause = 1 forces req_ready = 0 for all requesters, and rr_ptr holds its value.
- On a grant to requester i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Staging register, updated every cycle:
  - wb_en <= grant & (granted addr != 0)
  - wb_addr <= granted addr and wb_data <= granted data, only when a grant occurs; otherwise both hold.
- Writes to address 0 (the hardwired zero register) are handshaked (ready = 1, so the transfer completes) but dropped: wb_en stays 0.
- Forwarding, combinational:
  - fwd_hit_k = wb_en & (wb_addr == rd_addr_k)
  - fwd_hit_k is never 1 for address 0, because wb_en is never set for address 0.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not buffer unaccepted requests.

## Timing
- Reset values: rr_ptr = 0, wb_en = 0, wb_addr = 0, wb_data = 0, req_ready = 0, fwd_hit_* = 0.
- Latency: request accepted in cycle N, wb_en high in cycle N+1, register file updated at the end of cycle N+1.
- Throughput: one write per cycle. A requester that is continuously valid alongside K−1 others is granted at least once every K cycles.
- Back-to-back writes to the same address: the later grant overwrites the staging register and the register file sees both writes, in order.
- pause rising in cycle N: no grant in N, so wb_en = 0 in N+1. A write already staged in N still completes in N.
- Reset asserted mid-operation: staging is cleared immediately and the staged write is lost. Requesters re-present after reset.

## Structure
- Package reg_wb_pkg holds:
  - ZERO_REG_ADDR constant (0)
  - the max NUM_REQ constant
  - a wb_req_t struct {addr, data}, parameterized via localparam widths
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs: req vector, pointer, enable
  - outputs: one-hot grant, grant index
- The top level holds rr_ptr, the staging register and the forwarding compares.

## Test plan
- Single request: req0 valid, addr 5, data 0xA5 → req_ready[0] = 1 in the same cycle; next cycle wb_en = 1, wb_addr = 5, wb_data = 0xA5.
- Contention, NUM_REQ = 2: both requesters continuously valid for 6 cycles, rr_ptr = 0 → grants alternate 0,1,0,1,0,1 and wb_en stays high every cycle after the first.
- Zero register: req1 writes addr 0, data 0xFF → req_ready[1] = 1, next cycle wb_en = 0, and rr_ptr advances to 0.
- Forwarding: staged write addr 3, data 0x3C with rd_addr_1 = 3 and rd_addr_2 = 4 → fwd_hit_1 = 1, fwd_hit_2 = 0, fwd_data = 0x3C.
- Pause: pause high for 3 cycles with both requesters valid → req_ready = 0 and wb_en = 0 for those cycles, and rr_ptr is unchanged. After release, granting resumes from the held pointer.
- Async reset mid-stream: assert rst between clock edges while wb_en = 1 → wb_en, wb_addr and wb_data go to 0 immediately, and the first grant after reset goes to requester 0.
